// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader that fronts the RV32I core.
package loader_pkg;

  localparam int NUM_REGS = 32;
  localparam int RUN_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP,
    DONE
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams a program into IMEM with the core held in reset, runs the core for a
// fixed number of cycles, then streams x0..x31 back out of the register file.
module prog_loader
  import loader_pkg::*;
#(
  parameter  int IMEM_DEPTH = 256,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_load,
  input  logic [15:0]      run_cycles,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             core_n_rst,
  output logic             core_run,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  loader_state_t    r_state;
  loader_state_t    w_nextState;

  logic [AW-1:0]    r_waddr;
  logic             r_loadEnd;
  logic [RUN_W-1:0] r_runLen;
  logic [RUN_W-1:0] r_runCnt;
  logic [4:0]       r_idx;

  logic             r_imemWe;
  logic [AW-1:0]    r_imemWaddr;
  logic [31:0]      r_imemWdata;
  logic             r_outValid;
  logic             r_outLast;
  logic [31:0]      r_outData;

  logic             w_inReady;
  logic             w_coreNRst;
  logic             w_coreRun;
  logic             w_busy;
  logic             w_done;
  logic             w_start;
  logic             w_inHs;
  logic             w_outHs;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // LOAD lingers one extra cycle after its final handshake so the last write
  // commits while the core is still in reset.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_coreNRst  = 1'b0;
    w_coreRun   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_load) w_nextState = LOAD;
      end
      LOAD: begin
        w_busy    = 1'b1;
        w_inReady = !r_loadEnd;
        if (r_loadEnd) w_nextState = (r_runLen == '0) ? DUMP : RUN;
      end
      RUN: begin
        w_busy     = 1'b1;
        w_coreNRst = 1'b1;
        w_coreRun  = 1'b1;
        if (r_runCnt == RUN_W'(1)) w_nextState = DUMP;
      end
      DUMP: begin
        w_busy     = 1'b1;
        w_coreNRst = 1'b1;
        if (w_outHs && r_outLast) w_nextState = DONE;
      end
      DONE: begin
        w_coreNRst = 1'b1;
        w_done     = 1'b1;
        if (start_load) w_nextState = LOAD;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_start = start_load && ((r_state == IDLE) || (r_state == DONE));
  assign w_inHs  = in_valid && w_inReady;
  assign w_outHs = r_outValid && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_waddr     <= '0;
      r_loadEnd   <= 1'b0;
      r_runLen    <= '0;
      r_runCnt    <= '0;
      r_idx       <= '0;
      r_imemWe    <= 1'b0;
      r_imemWaddr <= '0;
      r_imemWdata <= '0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
      r_outData   <= '0;
    end else begin
      r_imemWe <= w_inHs;

      if (w_start) begin
        r_runLen  <= run_cycles;
        r_waddr   <= '0;
        r_runCnt  <= '0;
        r_loadEnd <= 1'b0;
        r_idx     <= '0;
      end

      // The top address ends the load so the program truncates instead of wrapping.
      if (w_inHs) begin
        r_imemWaddr <= r_waddr;
        r_imemWdata <= in_data;
        r_waddr     <= r_waddr + AW'(1);
        if (in_last || (r_waddr == AW'(IMEM_DEPTH - 1))) r_loadEnd <= 1'b1;
      end

      if ((r_state == LOAD) && r_loadEnd) begin
        r_runCnt <= r_runLen;
      end else if (r_state == RUN) begin
        r_runCnt <= r_runCnt - RUN_W'(1);
      end

      // Capture the next register whenever the output slot is empty or draining.
      if (r_state == DUMP) begin
        if (w_outHs && r_outLast) begin
          r_outValid <= 1'b0;
          r_outLast  <= 1'b0;
        end else if (!r_outValid || w_outHs) begin
          r_outData  <= rf_rdata;
          r_outValid <= 1'b1;
          r_outLast  <= (r_idx == 5'(NUM_REGS - 1));
          r_idx      <= r_idx + 5'd1;
        end
      end
    end
  end

  assign in_ready   = w_inReady;
  assign imem_we    = r_imemWe;
  assign imem_waddr = r_imemWaddr;
  assign imem_wdata = r_imemWdata;
  assign core_n_rst = w_coreNRst;
  assign core_run   = w_coreRun;
  assign rf_raddr   = r_idx;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign out_last   = r_outLast;
  assign busy       = w_busy;
  assign done       = w_done;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with a tiny RV32I core model behind it.
module tb_prog_loader;

  logic        clk;
  logic        n_rst;
  logic        start_load;
  logic [15:0] run_cycles;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_n_rst;
  logic        core_run;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic        start8;
  logic [15:0] runCycles8;
  logic        inValid8;
  logic [31:0] inData8;
  logic        inLast8;
  logic        inReady8;
  logic        imemWe8;
  logic [2:0]  imemWaddr8;
  logic [31:0] imemWdata8;
  logic        coreNRst8;
  logic        coreRun8;
  logic [4:0]  rfRaddr8;
  logic [31:0] rfRdata8;
  logic        outValid8;
  logic [31:0] outData8;
  logic        outLast8;
  logic        outReady8;
  logic        busy8;
  logic        done8;

  prog_loader #(.IMEM_DEPTH(256)) dut (
    .clk(clk), .n_rst(n_rst), .start_load(start_load), .run_cycles(run_cycles),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_n_rst(core_n_rst), .core_run(core_run), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  prog_loader #(.IMEM_DEPTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .start_load(start8), .run_cycles(runCycles8),
    .in_valid(inValid8), .in_data(inData8), .in_last(inLast8), .in_ready(inReady8),
    .imem_we(imemWe8), .imem_waddr(imemWaddr8), .imem_wdata(imemWdata8),
    .core_n_rst(coreNRst8), .core_run(coreRun8), .rf_raddr(rfRaddr8), .rf_rdata(rfRdata8),
    .out_valid(outValid8), .out_data(outData8), .out_last(outLast8), .out_ready(outReady8),
    .busy(busy8), .done(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Minimal core: ADDI, ADD/SUB, BEQ/BNE, JAL; RF cleared while held in reset.
  logic [31:0] imemModel [256];
  logic [31:0] rfModel [32];
  logic [7:0]  corePc;
  logic [31:0] coreInstr, rs1Val, rs2Val, bImm, jImm, wbVal;
  logic [7:0]  nextPc;
  logic        wbEn;

  always_comb begin
    coreInstr = imemModel[corePc];
    rs1Val    = (coreInstr[19:15] == 5'd0) ? 32'd0 : rfModel[coreInstr[19:15]];
    rs2Val    = (coreInstr[24:20] == 5'd0) ? 32'd0 : rfModel[coreInstr[24:20]];
    bImm      = {{20{coreInstr[31]}}, coreInstr[7], coreInstr[30:25], coreInstr[11:8], 1'b0};
    jImm      = {{12{coreInstr[31]}}, coreInstr[19:12], coreInstr[20], coreInstr[30:21], 1'b0};
    nextPc    = corePc + 8'd1;
    wbEn      = 1'b0;
    wbVal     = 32'd0;
    case (coreInstr[6:0])
      7'h13: begin
        wbEn  = (coreInstr[14:12] == 3'd0);
        wbVal = rs1Val + {{20{coreInstr[31]}}, coreInstr[31:20]};
      end
      7'h33: begin
        wbEn  = 1'b1;
        wbVal = coreInstr[30] ? (rs1Val - rs2Val) : (rs1Val + rs2Val);
      end
      7'h63: begin
        if (((coreInstr[14:12] == 3'd0) && (rs1Val == rs2Val)) ||
            ((coreInstr[14:12] == 3'd1) && (rs1Val != rs2Val)))
          nextPc = corePc + bImm[9:2];
      end
      7'h6F: begin
        wbEn   = 1'b1;
        wbVal  = {22'd0, corePc, 2'b00} + 32'd4;
        nextPc = corePc + jImm[9:2];
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (imem_we) imemModel[imem_waddr] <= imem_wdata;
    if (!core_n_rst) begin
      corePc <= 8'd0;
      for (int i = 0; i < 32; i++) rfModel[i] <= 32'd0;
    end else if (core_run) begin
      corePc <= nextPc;
      if (wbEn && (coreInstr[11:7] != 5'd0)) rfModel[coreInstr[11:7]] <= wbVal;
    end
  end

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rfModel[rf_raddr];

  logic [39:0] wrQ[$];
  logic [32:0] dumpQ[$];
  logic [31:0] prog[$];
  logic [31:0] expRf [32];
  int  runCount, hsCount, wrCount, cyc, firstWr, lastWr, wr8;
  logic doneCheckPending;
  logic readyMode;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = readyMode ? !out_ready : 1'b1;
    end
  end

  // Monitor: pops expected writes and dump words as the DUT presents them.
  initial begin
    cyc = 0; wrCount = 0; runCount = 0; hsCount = 0; wr8 = 0;
    doneCheckPending = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (doneCheckPending) begin
        checkOutput("doneAfterX31", done, 1);
        doneCheckPending = 1'b0;
      end
      if (imem_we) begin
        if (wrQ.size() == 0) checkOutput("unexpectedWrite", imem_we, 0);
        else checkOutput("imemWrite", {imem_waddr, imem_wdata}, wrQ.pop_front());
        checkOutput("coreHeldInLoad", core_n_rst, 0);
        if (wrCount == 0) firstWr = cyc;
        lastWr = cyc;
        wrCount++;
      end
      if (core_run) runCount++;
      if (out_valid) begin
        if (dumpQ.size() == 0) checkOutput("unexpectedDump", out_valid, 0);
        else begin
          checkOutput("dumpWord", {out_last, out_data}, dumpQ[0]);
          if (out_ready) begin
            void'(dumpQ.pop_front());
            hsCount++;
            if (out_last) doneCheckPending = 1'b1;
          end
        end
      end
      if (imemWe8) begin
        checkOutput("ovfWrite", {imemWaddr8, imemWdata8}, {wr8[2:0], 32'h100 + wr8});
        wr8++;
      end
    end
  end

  task automatic loadProgram(input logic [15:0] rc);
    logic got;
    wrCount = 0; runCount = 0; hsCount = 0;
    @(posedge clk); #1;
    start_load = 1'b1;
    run_cycles = rc;
    @(posedge clk); #1;
    start_load = 1'b0;
    run_cycles = 16'hFFFF;
    checkOutput("inReadyAfterStart", {in_ready, busy, done}, 3'b110);
    for (int k = 0; k < prog.size(); k++) begin
      in_valid = 1'b1;
      in_data  = prog[k];
      in_last  = (k == prog.size() - 1);
      wrQ.push_back({k[7:0], prog[k]});
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) checkOutput("loadHandshakeTimeout", got, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'd0;
    checkOutput("lastWriteCycle", {imem_we, core_n_rst, in_ready}, 3'b100);
    @(posedge clk); #1;
    checkOutput("coreReleased", {core_n_rst, core_run}, {1'b1, rc != 16'd0});
  endtask

  task automatic waitDone(input logic pulseInDump);
    logic ok, pulsed;
    ok = 1'b0;
    pulsed = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      if (pulseInDump && !pulsed && out_valid) begin
        start_load = 1'b1;
        pulsed = 1'b1;
      end else begin
        start_load = 1'b0;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start_load = 1'b0;
    checkOutput("doneReached", ok, 1);
  endtask

  task automatic applyStimulus(input logic [15:0] rc, input logic pulseInDump);
    loadProgram(rc);
    for (int r = 0; r < 32; r++) dumpQ.push_back({(r == 31), expRf[r]});
    waitDone(pulseInDump);
    checkOutput("dumpHandshakes", hsCount, 32);
    checkOutput("dumpQueueEmpty", dumpQ.size(), 0);
    checkOutput("runCycles", runCount, rc);
  endtask

  task automatic clearExp();
    for (int r = 0; r < 32; r++) expRf[r] = 32'd0;
  endtask

  int k8;

  initial begin
    n_rst = 1'b0; start_load = 1'b0; run_cycles = 16'd0;
    in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; readyMode = 1'b0;
    start8 = 1'b0; runCycles8 = 16'd0; inValid8 = 1'b0; inData8 = 32'd0;
    inLast8 = 1'b0; outReady8 = 1'b1; rfRdata8 = 32'd0;

    #2;
    checkOutput("rstControls", {in_ready, imem_we, core_n_rst, core_run, out_valid, out_last, busy, done}, 0);
    checkOutput("rstImemBus", {imem_waddr, imem_wdata}, 0);
    checkOutput("rstDumpBus", {rf_raddr, out_data}, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // test1_arith: addi x1,10; addi x2,5; add x3; sub x4; nop; jal x0,0
    prog = {32'h00A00093, 32'h00500113, 32'h002081B3, 32'h40208233, 32'h00000013, 32'h0000006F};
    clearExp();
    expRf[1] = 32'd10; expRf[2] = 32'd5; expRf[3] = 32'd15; expRf[4] = 32'd5;
    applyStimulus(16'd7, 1'b0);
    checkOutput("t1WriteCount", wrCount, 6);
    checkOutput("t1WritesBackToBack", lastWr - firstWr, 5);

    // test3_branch: x2=5; x1=0; loop x1++ until x1==x2; jal x0,0
    prog = {32'h00500113, 32'h00000093, 32'h00108093, 32'hFE209EE3, 32'h0000006F};
    clearExp();
    expRf[1] = 32'd5; expRf[2] = 32'd5;
    readyMode = 1'b1;
    applyStimulus(16'd19, 1'b0);
    readyMode = 1'b0;
    checkOutput("t3WriteCount", wrCount, 5);

    prog = {32'h00A00093, 32'h00500113, 32'h002081B3, 32'h40208233, 32'h00000013, 32'h0000006F};
    clearExp();
    applyStimulus(16'd0, 1'b1);
    @(posedge clk); #1;
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    checkOutput("restartFromDone", {done, in_ready, busy}, 3'b011);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;

    prog = {32'h00A00093, 32'h0000006F};
    loadProgram(16'd100);
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b0;
    #1 checkOutput("rstMidRun", {core_n_rst, core_run, busy, done, in_ready, out_valid}, 0);
    @(posedge clk); #1;
    checkOutput("idleAfterRst", {busy, core_n_rst, imem_we}, 0);
    n_rst = 1'b1;

    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    k8 = 0;
    for (int t = 0; t < 20; t++) begin
      inValid8 = (k8 < 10);
      inData8  = 32'h100 + k8;
      @(negedge clk);
      if (inValid8 && inReady8) k8++;
      @(posedge clk); #1;
    end
    inValid8 = 1'b0;
    checkOutput("ovfAccepted", k8, 8);
    checkOutput("ovfWrites", wr8, 8);
    checkOutput("ovfReadyLow", inReady8, 0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
